// File: rtl/mc_pkg.sv
// mc_pkg: shared op/state enums and default FORM/PROG/SENSE timing for the RRAM array model
package mc_pkg;
  typedef enum logic [1:0] {MC_READ = 2'd0, MC_PROG = 2'd1, MC_FORM = 2'd2} mc_op_e;
  typedef enum logic [2:0] {IDLE, FORM, PROG, SENSE, DONE} mc_state_e;
  localparam int MC_FORM_CYCLES = 16;
  localparam int MC_PROG_CYCLES = 4;
  localparam int MC_SENSE_CYCLES = 2;
endpackage

// File: rtl/mc_array_model_if.sv
// mc_array_model_if: controller<->array bus; master drives op/word/bit/select/data lines, slave returns ready/dout/valid/busy/err
interface mc_array_model_if #(parameter int NROWS = 64, parameter int NCOLS = 64) ();
  import mc_pkg::*;
  logic op_valid_i;
  logic op_ready_o;
  mc_op_e op_i;
  logic [NROWS/2-1:0] cwle_i;
  logic [NROWS/2-1:0] cwlo_i;
  logic [NCOLS-1:0] csl_i;
  logic [NCOLS-1:0] cblen_i;
  logic [NCOLS-1:0] din_i;
  logic [NCOLS-1:0] dinb_i;
  logic [NCOLS-1:0] dout_o;
  logic dout_valid_o;
  logic busy_o;
  logic err_o;
  modport master (output op_valid_i, op_i, cwle_i, cwlo_i, csl_i, cblen_i, din_i, dinb_i,
                  input op_ready_o, dout_o, dout_valid_o, busy_o, err_o);
  modport slave (input op_valid_i, op_i, cwle_i, cwlo_i, csl_i, cblen_i, din_i, dinb_i,
                 output op_ready_o, dout_o, dout_valid_o, busy_o, err_o);
endinterface

// File: rtl/mc_op_timer.sv
// mc_op_timer: loadable down-counter stopping at 0; ports clk_i, rst_ni, load_i, value_i -> done_o (count==0)
module mc_op_timer #(parameter int W = 5) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else if (load_i) cnt_q <= value_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/mc_array_model.sv
// mc_array_model: 2T2R RRAM array model with FORM/PROG/READ timing; ports clk_i, rst_ni (sync active-low), bus (slave: op handshake, word/select/data lines, dout/valid/busy/err)
module mc_array_model import mc_pkg::*; #(
  parameter int NROWS = 64,
  parameter int NCOLS = 64,
  parameter int FORM_CYCLES = MC_FORM_CYCLES,
  parameter int PROG_CYCLES = MC_PROG_CYCLES,
  parameter int SENSE_CYCLES = MC_SENSE_CYCLES
) (
  input logic clk_i,
  input logic rst_ni,
  mc_array_model_if.slave bus
);
  localparam int MAXC = FORM_CYCLES > PROG_CYCLES ? (FORM_CYCLES > SENSE_CYCLES ? FORM_CYCLES : SENSE_CYCLES)
                                                  : (PROG_CYCLES > SENSE_CYCLES ? PROG_CYCLES : SENSE_CYCLES);
  localparam int TW = $clog2(MAXC) + 1;
  localparam int RW = $clog2(NROWS);
  logic [NROWS-1:0][NCOLS-1:0] data_q = '0;
  logic [NROWS-1:0][NCOLS-1:0] formed_q = '0;
  mc_state_e state_q;
  logic [RW-1:0] row_q, row_idx;
  logic [NCOLS-1:0] csl_q, cblen_q, din_q, dinb_q, dout_q, frow, wmask;
  logic [NROWS-1:0] rows;
  logic dv_q, err_q, req_ok, accept, tdone;
  logic [TW-1:0] tval;
  always_comb begin
    rows = '0;
    row_idx = '0;
    for (int k = 0; k < NROWS/2; k++) begin
      rows[2*k] = bus.cwle_i[k];
      rows[2*k+1] = bus.cwlo_i[k];
    end
    for (int r = 0; r < NROWS; r++) if (rows[r]) row_idx = RW'(r);
  end
  assign req_ok = $onehot(rows) && (bus.op_i inside {MC_READ, MC_PROG, MC_FORM});
  assign accept = state_q == IDLE && bus.op_valid_i;
  assign tval = bus.op_i == MC_FORM ? TW'(FORM_CYCLES - 1) :
                bus.op_i == MC_PROG ? TW'(PROG_CYCLES - 1) : TW'(SENSE_CYCLES - 1);
  assign frow = formed_q[row_q];
  // only formed columns with a complementary din/dinb pair get written
  assign wmask = csl_q & frow & (din_q ^ dinb_q);
  mc_op_timer #(.W(TW)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (accept && req_ok),
    .value_i(tval),
    .done_o (tdone)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dout_q <= '0;
      dv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          err_q <= !req_ok;
          if (req_ok) begin
            row_q <= row_idx;
            csl_q <= bus.csl_i;
            cblen_q <= bus.cblen_i;
            din_q <= bus.din_i;
            dinb_q <= bus.dinb_i;
            state_q <= bus.op_i == MC_FORM ? FORM : bus.op_i == MC_PROG ? PROG : SENSE;
          end
        end
        FORM: if (tdone) begin
          formed_q[row_q] <= frow | csl_q;
          data_q[row_q] <= data_q[row_q] & ~(csl_q & ~frow);
          state_q <= DONE;
        end
        PROG: if (tdone) begin
          data_q[row_q] <= (data_q[row_q] & ~wmask) | (din_q & wmask);
          err_q <= |(csl_q & ~wmask);
          state_q <= DONE;
        end
        SENSE: if (tdone) begin
          dout_q <= data_q[row_q] & cblen_q & frow;
          dv_q <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.op_ready_o = state_q == IDLE;
  assign bus.busy_o = state_q != IDLE;
  assign bus.dout_o = dout_q;
  assign bus.dout_valid_o = dv_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_mc_array_model.sv
// tb_mc_array_model: scoreboard bench for mc_array_model with a per-bit behavioural cell model
module tb_mc_array_model;
  import mc_pkg::*;
  localparam logic [63:0] ALL = '1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mc_array_model_if #(.NROWS(64), .NCOLS(64)) bus ();
  mc_array_model dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  int n_chk = 0, n_err = 0, got_err = 0, exp_err = 0, cyc = 0;
  logic [63:0] m_data [64];
  logic [63:0] m_form [64];
  logic [63:0] exp_q [$];
  int acc_q [$];
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.err_o === 1'b1) got_err++;
    if (bus.dout_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        check("rd_data", bus.dout_o, exp_q.pop_front());
        check("rd_latency", 64'(cyc - acc_q.pop_front()), 64'(MC_SENSE_CYCLES));
      end
    end
  end
  function automatic logic [31:0] oh(input int k);
    logic [31:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.op_ready_o === 1'b1) return;
    end
    check("idle_timeout", 64'(bus.op_ready_o), 64'd1);
  endtask
  task automatic issue(input mc_op_e op, input logic [31:0] we, input logic [31:0] wo,
                       input logic [63:0] csl, input logic [63:0] cbl, input logic [63:0] d,
                       input logic [63:0] db, input bit apply);
    logic [63:0] rows, rd;
    int idx;
    bit perr;
    wait_idle();
    bus.op_i = op;
    bus.cwle_i = we;
    bus.cwlo_i = wo;
    bus.csl_i = csl;
    bus.cblen_i = cbl;
    bus.din_i = d;
    bus.dinb_i = db;
    bus.op_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid_i = 1'b0;
    bus.din_i = ~d;
    bus.csl_i = ~csl;
    for (int k = 0; k < 32; k++) begin
      rows[2*k] = we[k];
      rows[2*k+1] = wo[k];
    end
    if (!apply) return;
    if ($countones(rows) != 1 || !(op inside {MC_READ, MC_PROG, MC_FORM})) begin
      exp_err++;
      return;
    end
    idx = 0;
    for (int r = 0; r < 64; r++) if (rows[r]) idx = r;
    perr = 0;
    rd = '0;
    for (int c = 0; c < 64; c++) begin
      if (op == MC_FORM && csl[c] && !m_form[idx][c]) begin
        m_form[idx][c] = 1'b1;
        m_data[idx][c] = 1'b0;
      end
      if (op == MC_PROG && csl[c]) begin
        if (!m_form[idx][c] || d[c] == db[c]) perr = 1;
        else m_data[idx][c] = d[c];
      end
      if (op == MC_READ && cbl[c] && m_form[idx][c]) rd[c] = m_data[idx][c];
    end
    if (perr) exp_err++;
    if (op == MC_READ) begin
      exp_q.push_back(rd);
      acc_q.push_back(cyc);
    end
  endtask
  task automatic op_row(input mc_op_e op, input int r, input logic [63:0] csl, input logic [63:0] cbl,
                        input logic [63:0] d, input logic [63:0] db);
    issue(op, r % 2 ? 32'd0 : oh(r / 2), r % 2 ? oh(r / 2) : 32'd0, csl, cbl, d, db, 1'b1);
  endtask
  task automatic chk_err(input string tag);
    wait_idle();
    @(negedge clk);
    #1;
    check(tag, 64'(got_err), 64'(exp_err));
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] d, db, x;
    int r;
    for (int i = 0; i < 64; i++) begin
      m_data[i] = '0;
      m_form[i] = '0;
    end
    bus.op_valid_i = 1'b0;
    bus.op_i = MC_READ;
    bus.cwle_i = '0;
    bus.cwlo_i = '0;
    bus.csl_i = '0;
    bus.cblen_i = '0;
    bus.din_i = '0;
    bus.dinb_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.op_ready_o), 64'd1);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.dout_valid_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_dout", bus.dout_o, 64'd0);
    rst_n = 1'b1;
    op_row(MC_READ, 0, '0, ALL, '0, '0);
    check("read_busy", 64'(bus.busy_o), 64'd1);
    chk_err("err_read0");
    op_row(MC_FORM, 5, ALL, '0, '0, '0);
    check("form_ready", 64'(bus.op_ready_o), 64'd0);
    op_row(MC_PROG, 5, ALL, '0, 64'hA5A5_A5A5_A5A5_A5A5, ~64'hA5A5_A5A5_A5A5_A5A5);
    op_row(MC_READ, 5, '0, ALL, '0, '0);
    chk_err("err_a5");
    d = 64'h0F0F_0F0F_0F0F_0F08;
    db = ~d;
    db[3] = 1'b1;
    op_row(MC_PROG, 5, ALL, '0, d, db);
    op_row(MC_READ, 5, '0, ALL, '0, '0);
    chk_err("err_inhibit");
    issue(MC_READ, '0, '0, '0, ALL, '0, '0, 1'b1);
    check("norow_err", 64'(bus.err_o), 64'd1);
    check("norow_ready", 64'(bus.op_ready_o), 64'd1);
    check("norow_busy", 64'(bus.busy_o), 64'd0);
    chk_err("err_norow");
    op_row(MC_FORM, 0, ALL, '0, '0, '0);
    op_row(MC_FORM, 1, ALL, '0, '0, '0);
    issue(MC_PROG, 32'd1, 32'd1, ALL, '0, ALL, '0, 1'b1);
    check("dual_err", 64'(bus.err_o), 64'd1);
    check("dual_ready", 64'(bus.op_ready_o), 64'd1);
    op_row(MC_READ, 0, '0, ALL, '0, '0);
    op_row(MC_READ, 1, '0, ALL, '0, '0);
    chk_err("err_dual");
    issue(mc_op_e'(2'd3), oh(1), '0, ALL, ALL, ALL, '0, 1'b1);
    check("rsvd_err", 64'(bus.err_o), 64'd1);
    chk_err("err_rsvd");
    op_row(MC_PROG, 9, ALL, '0, ALL, '0);
    op_row(MC_READ, 9, '0, ALL, '0, '0);
    chk_err("err_unformed");
    x = 64'hDEAD_BEEF_0123_4567;
    op_row(MC_FORM, 7, ALL, '0, '0, '0);
    op_row(MC_PROG, 7, ALL, '0, x, ~x);
    op_row(MC_READ, 7, '0, ALL, '0, '0);
    issue(MC_PROG, '0, oh(3), ALL, '0, ~x, x, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_ready", 64'(bus.op_ready_o), 64'd1);
    check("abort_busy", 64'(bus.busy_o), 64'd0);
    check("abort_dout", bus.dout_o, 64'd0);
    op_row(MC_READ, 7, '0, ALL, '0, '0);
    chk_err("err_abort");
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(10, 63);
      d = {$urandom, $urandom};
      op_row(MC_FORM, r, {$urandom, $urandom}, '0, '0, '0);
      op_row(MC_PROG, r, {$urandom, $urandom}, '0, d, ~d ^ (64'd1 << $urandom_range(0, 63)));
      op_row(MC_READ, r, '0, {$urandom, $urandom}, '0, '0);
    end
    chk_err("err_random");
    repeat (5) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
